ram_message_sequencer: RTL and testbench
========================================

Name: ram_message_sequencer

Overview:
Controller for the 43x7 message RAM used by the lab's serial terminal. It owns the RAM's address, write-data and write-enable pins, and shares that single port between two requesters. An edit requester writes characters into an editable window. A print engine walks the RAM from address 0 and hands each character to the UART transmitter over a valid/ready handshake, stopping at NUL. After reset it also clears the editable window to spaces.

Parameters:
DATA_WIDTH, 7, RAM word width (7-bit ASCII)
ADDR_WIDTH, 6, RAM address width
MEM_SIZE, 43, number of RAM words; the last valid address is MEM_SIZE-1
EDIT_BASE, 24, first editable address
EDIT_LAST, 39, last editable address
FILL_CHAR, 7'h20, character written into the edit window during INIT

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; shared with the RAM
print_req  in  1  pulse; starts a print pass
char_in_valid  in  1  edit character offered
char_in  in  DATA_WIDTH  edit character
char_in_ready  out  1  edit character accepted this cycle when valid is also high
tx_data  out  8  byte to the UART, {1'b0, char}
tx_valid  out  1  tx_data is valid
tx_ready  in  1  UART accepts the byte
ram_address  out  ADDR_WIDTH  RAM address
ram_din  out  DATA_WIDTH  RAM write data
ram_write  out  1  RAM writeOrread (1 = write)
ram_dout  in  DATA_WIDTH  RAM combinational read data
edit_ptr  out  ADDR_WIDTH  next edit address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of a print pass

Behaviour:
- Reset: state=INIT, rd_ptr=0, edit_ptr=EDIT_BASE, fill_ptr=EDIT_BASE, tx_valid=0, tx_data=0, done=0, busy=1.
- State machine: INIT, IDLE, WRITE, FETCH, SEND, FIN.
- INIT:
  - ram_write=1, ram_address=fill_ptr, ram_din=FILL_CHAR.
  - fill_ptr increments by 1 each cycle.
  - When fill_ptr==EDIT_LAST, go to IDLE. INIT lasts exactly EDIT_LAST-EDIT_BASE+1 cycles (16).
- IDLE:
  - ram_write=0, ram_address=rd_ptr.
  - char_in_ready = (state==IDLE) && !print_req. print_req wins a same-cycle collision, and the character stays pending.
  - On print_req: rd_ptr<=0, go to FETCH.
  - Else on char_in_valid && char_in_ready: latch char_in, go to WRITE.
- WRITE (1 cycle):
  - ram_write=1, ram_address=edit_ptr, ram_din=latched char.
  - edit_ptr<=edit_ptr+1, wrapping from EDIT_LAST to EDIT_BASE.
  - Go to IDLE.
- FETCH (1 cycle):
  - ram_address=rd_ptr; ram_dout is sampled combinationally.
  - If ram_dout==0 (NUL), go to FIN.
  - Else tx_data<={1'b0, ram_dout}, tx_valid<=1, go to SEND.
- SEND:
  - tx_data and tx_valid are held stable until tx_ready is high.
  - On handshake: tx_valid<=0.
  - If rd_ptr==MEM_SIZE-1, go to FIN (bound on an unterminated string).
  - Else rd_ptr<=rd_ptr+1, go to FETCH.
- FIN: done=1 for one cycle, rd_ptr<=0, go to IDLE.
- Throughput: 2 cycles per character when tx_ready is held high. tx_valid never drops without a handshake, except on reset.
- print_req and char_in_valid are ignored whenever state!=IDLE. char_in_ready=0 in those states.
- ram_address, ram_din and ram_write are combinational from state and pointers. Outside INIT and WRITE, ram_write=0 and ram_din=0.
- Reset mid-pass or mid-INIT: next edge forces the reset values. tx_valid drops with no handshake. INIT restarts.

Decomposition:
- Shared package (serial_term_pkg):
  - state encoding
  - NUL=7'h00, LF=7'h0A, CR=7'h0D, FILL_CHAR
  - EDIT_BASE, EDIT_LAST, MEM_SIZE
- A single flat module is natural. The optional sub-module edit_ptr_wrap_counter holds the wrapping pointer shared by INIT and WRITE.

Test Plan:
- Reset with the RAM also in reset -> busy=1 for 16 cycles; ram_write=1 with ram_address 24..39 and ram_din=7'h20; then IDLE, busy=0, char_in_ready=1.
- char_in "A" (7'h41) for one cycle in IDLE -> next cycle ram_write=1, ram_address=24, ram_din=7'h41; edit_ptr=25.
- 17 consecutive edits "a".."q" -> the 17th write lands at address 24 (wrap); edit_ptr=25 afterwards.
- print_req with tx_ready=1 and no edits -> tx_data sequence 0A,0D,45,43,45,34,33,33,20,46,61,6C,6C,20,32,30,31,38,20,20,20,44,69,67, then 16x20, 0D, 0A. That is 42 bytes; NUL at address 42 is not sent; done pulses once; total 86 cycles from FETCH entry.
- tx_ready low for 5 cycles on the third byte -> tx_data=8'h45 and tx_valid=1 held for all 5 cycles; no rd_ptr advance; no byte lost or duplicated.
- print_req and char_in_valid asserted in the same IDLE cycle -> print starts; char_in_ready=0 until after the done pulse; then the edit is accepted. Reset asserted during the 10th byte -> tx_valid=0 after the edge and INIT restarts.

Source files
------------

// File: rtl/serial_term_pkg.sv
// Shared constants and state encoding for the serial terminal message path.
package serial_term_pkg;

  localparam int MEM_SIZE  = 43;
  localparam int EDIT_BASE = 24;
  localparam int EDIT_LAST = 39;

  localparam logic [6:0] NUL       = 7'h00;
  localparam logic [6:0] LF        = 7'h0A;
  localparam logic [6:0] CR        = 7'h0D;
  localparam logic [6:0] FILL_CHAR = 7'h20;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    WRITE = 3'd2,
    FETCH = 3'd3,
    SEND  = 3'd4,
    FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/edit_ptr_wrap_counter.sv
// Wrapping address pointer over the editable window; the same register serves
// as the fill pointer during INIT and as the edit pointer afterwards.
module edit_ptr_wrap_counter #(
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE       = 6'd24,
  parameter logic [ADDR_WIDTH-1:0] LAST       = 6'd39
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] value
);

  logic [ADDR_WIDTH-1:0] value_r;

  // Pointer register: steps on advance and wraps from LAST back to BASE
  always_ff @(posedge clock) begin
    if (reset) begin
      value_r <= BASE;
    end else if (advance) begin
      if (value_r == LAST) begin
        value_r <= BASE;
      end else begin
        value_r <= value_r + ADDR_WIDTH'(1);
      end
    end
  end

  assign value = value_r;

endmodule

// File: rtl/ram_message_sequencer.sv
// Single-port message RAM controller: clears the edit window after reset,
// accepts edit characters, and streams the stored message to the UART.
module ram_message_sequencer
  import serial_term_pkg::*;
#(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  print_req,
  input  logic                  char_in_valid,
  input  logic [DATA_WIDTH-1:0] char_in,
  output logic                  char_in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_write,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [ADDR_WIDTH-1:0] edit_ptr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(EDIT_BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_EDIT = ADDR_WIDTH'(EDIT_LAST);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_r, rd_ptr_s;
  logic [DATA_WIDTH-1:0] char_r, char_s;
  logic [7:0]            tx_data_r, tx_data_s;
  logic                  tx_valid_r, tx_valid_s;
  logic                  ptr_advance_s;
  logic [ADDR_WIDTH-1:0] wptr_s;

  edit_ptr_wrap_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE       (BASE_ADDR),
    .LAST       (LAST_EDIT)
  ) u_wptr (
    .clock   (clock),
    .reset   (reset),
    .advance (ptr_advance_s),
    .value   (wptr_s)
  );

  // Next-state, RAM port mux and handshake decode
  always_comb begin
    state_s       = state_r;
    rd_ptr_s      = rd_ptr_r;
    char_s        = char_r;
    tx_data_s     = tx_data_r;
    tx_valid_s    = tx_valid_r;
    ptr_advance_s = 1'b0;
    ram_address   = rd_ptr_r;
    ram_din       = {DATA_WIDTH{1'b0}};
    ram_write     = 1'b0;
    char_in_ready = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_r)
      INIT: begin
        ram_write     = 1'b1;
        ram_address   = wptr_s;
        ram_din       = DATA_WIDTH'(FILL_CHAR);
        ptr_advance_s = 1'b1;
        if (wptr_s == LAST_EDIT) begin
          state_s = IDLE;
        end else begin
          state_s = INIT;
        end
      end
      IDLE: begin
        busy          = 1'b0;
        char_in_ready = !print_req;
        // A print request wins; a simultaneous edit stays pending upstream
        if (print_req) begin
          rd_ptr_s = {ADDR_WIDTH{1'b0}};
          state_s  = FETCH;
        end else if (char_in_valid) begin
          char_s  = char_in;
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        ram_write     = 1'b1;
        ram_address   = wptr_s;
        ram_din       = char_r;
        ptr_advance_s = 1'b1;
        state_s       = IDLE;
      end
      FETCH: begin
        if (ram_dout == DATA_WIDTH'(NUL)) begin
          state_s = FIN;
        end else begin
          tx_data_s  = 8'(ram_dout);
          tx_valid_s = 1'b1;
          state_s    = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          tx_valid_s = 1'b0;
          // Last address reached without a NUL terminator ends the pass
          if (rd_ptr_r == LAST_ADDR) begin
            state_s = FIN;
          end else begin
            rd_ptr_s = rd_ptr_r + ADDR_WIDTH'(1);
            state_s  = FETCH;
          end
        end else begin
          state_s = SEND;
        end
      end
      FIN: begin
        done     = 1'b1;
        rd_ptr_s = {ADDR_WIDTH{1'b0}};
        state_s  = IDLE;
      end
      default: begin
        state_s = INIT;
      end
    endcase
  end

  // State, read pointer, latched edit character and UART output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= INIT;
      rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
      char_r     <= {DATA_WIDTH{1'b0}};
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      rd_ptr_r   <= rd_ptr_s;
      char_r     <= char_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign edit_ptr = wptr_s;

endmodule

// File: tb/tb_ram_message_sequencer.sv
// Directed plus randomized bench for ram_message_sequencer with a RAM model
// and a message-level reference model (expected RAM contents and edit slot).
module tb_ram_message_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       print_req;
  logic       char_in_valid;
  logic [6:0] char_in;
  logic       char_in_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [5:0] ram_address;
  logic [6:0] ram_din;
  logic       ram_write;
  logic [6:0] ram_dout;
  logic [5:0] edit_ptr;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [6:0] ram [0:63];
  logic [6:0] exp_mem [0:42];
  int         exp_ptr;
  logic [7:0] exp_q [$];

  always #5 clock = ~clock;

  ram_message_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .print_req     (print_req),
    .char_in_valid (char_in_valid),
    .char_in       (char_in),
    .char_in_ready (char_in_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .ram_address   (ram_address),
    .ram_din       (ram_din),
    .ram_write     (ram_write),
    .ram_dout      (ram_dout),
    .edit_ptr      (edit_ptr),
    .busy          (busy),
    .done          (done)
  );

  // Power-on / reset contents of the message RAM
  function automatic logic [6:0] rom_byte(input int a);
    string banner;
    banner = "\n\rECE433 Fall 2018   Dig";
    if (a < 24)       return 7'(banner[a]);
    else if (a < 40)  return 7'h20;
    else if (a == 40) return 7'h0D;
    else if (a == 41) return 7'h0A;
    else              return 7'h00;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= rom_byte(i);
    end else if (ram_write) begin
      ram[ram_address] <= ram_din;
    end
  end
  assign ram_dout = ram[ram_address];

  function automatic void model_reset();
    for (int a = 0; a < 43; a++) exp_mem[a] = rom_byte(a);
    exp_ptr = 24;
  endfunction

  function automatic void model_edit(input logic [6:0] c);
    exp_mem[exp_ptr] = c;
    exp_ptr = (exp_ptr == 39) ? 24 : exp_ptr + 1;
  endfunction

  function automatic void model_print();
    exp_q.delete();
    for (int a = 0; a < 43; a++) begin
      if (exp_mem[a] == 7'h00) break;
      exp_q.push_back({1'b0, exp_mem[a]});
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_and_init();
    reset = 1'b1;
    cyc();
    cyc();
    #3;
    check("rst_busy", busy, 1);
    check("rst_txv", tx_valid, 0);
    check("rst_txd", tx_data, 0);
    check("rst_done", done, 0);
    check("rst_eptr", edit_ptr, 24);
    check("rst_ready", char_in_ready, 0);
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        cyc();
        #3;
      end
      check("init_we", ram_write, 1);
      check("init_addr", ram_address, 24 + i);
      check("init_din", ram_din, 7'h20);
      check("init_busy", busy, 1);
    end
    cyc();
    #3;
    check("init_idle_busy", busy, 0);
    check("init_idle_ready", char_in_ready, 1);
    check("init_idle_eptr", edit_ptr, 24);
    check("init_idle_we", ram_write, 0);
    cyc();
  endtask

  task automatic do_edit(input logic [6:0] c);
    char_in_valid = 1'b1;
    char_in = c;
    #3;
    check("edit_ready", char_in_ready, 1);
    cyc();
    char_in_valid = 1'b0;
    #3;
    check("edit_we", ram_write, 1);
    check("edit_addr", ram_address, exp_ptr);
    check("edit_din", ram_din, c);
    model_edit(c);
    cyc();
    #3;
    check("edit_ptr", edit_ptr, exp_ptr);
    check("edit_idle", busy, 0);
    cyc();
  endtask

  task automatic start_print();
    print_req = 1'b1;
    #3;
    check("req_ready_low", char_in_ready, 0);
    check("req_idle", busy, 0);
    cyc();
    print_req = 1'b0;
    model_print();
  endtask

  // Consume one print pass; stall_at/stall_len hold tx_ready low on one byte
  task automatic watch_print(input int stall_at, input int stall_len, input bit rnd);
    int n = 0;
    int got = 0;
    int stall_cnt = 0;
    bit fin = 1'b0;
    bit prev_v = 1'b0;
    bit prev_hs = 1'b0;
    logic [7:0] prev_d = 8'h00;
    while (!fin && n < 3000) begin
      if (tx_valid && got == stall_at && stall_cnt < stall_len) begin
        tx_ready = 1'b0;
        stall_cnt++;
      end else begin
        tx_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #3;
      n++;
      check("pass_busy", busy, 1);
      check("pass_ready_low", char_in_ready, 0);
      if (prev_v && !prev_hs) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_d);
      end
      if (tx_valid && tx_ready) begin
        if (got < exp_q.size()) check("tx_byte", tx_data, exp_q[got]);
        else check("tx_count_over", got + 1, exp_q.size());
        got++;
      end
      if (done) fin = 1'b1;
      prev_v = tx_valid;
      prev_hs = tx_valid && tx_ready;
      prev_d = tx_data;
      cyc();
    end
    tx_ready = 1'b0;
    check("done_seen", fin, 1);
    check("tx_count", got, exp_q.size());
    if (!rnd) check("pass_cycles", n, 2 * exp_q.size() + ((exp_q.size() == 43) ? 1 : 2) + stall_len);
    #3;
    check("done_pulse", done, 0);
    check("post_idle", busy, 0);
    check("post_ready", char_in_ready, 1);
    cyc();
  endtask

  task automatic compare_mem();
    for (int a = 0; a < 43; a++) check("mem", ram[a], exp_mem[a]);
  endtask

  initial begin
    int k;
    int hs;
    int n;
    bit hit;
    reset = 1'b1;
    print_req = 1'b0;
    char_in_valid = 1'b0;
    char_in = 7'h00;
    tx_ready = 1'b0;
    reset_and_init();

    start_print();
    check("default_len", exp_q.size(), 42);
    watch_print(-1, 0, 1'b0);

    start_print();
    check("stall_byte", exp_q[2], 8'h45);
    watch_print(2, 5, 1'b0);

    do_edit(7'h41);
    reset_and_init();
    for (int i = 0; i < 17; i++) do_edit(7'(8'h61 + i));
    check("wrap_slot", exp_mem[24], 7'h71);
    compare_mem();

    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(0, 20);
      for (int e = 0; e < k; e++) do_edit(7'($urandom_range(0, 127)));
      start_print();
      watch_print(-1, 0, 1'b1);
    end
    compare_mem();

    // Print request and edit offered in the same IDLE cycle
    print_req = 1'b1;
    char_in_valid = 1'b1;
    char_in = 7'h5A;
    #3;
    check("coll_ready", char_in_ready, 0);
    check("coll_idle", busy, 0);
    cyc();
    print_req = 1'b0;
    model_print();
    watch_print(-1, 0, 1'b0);
    char_in_valid = 1'b0;
    #3;
    check("coll_we", ram_write, 1);
    check("coll_addr", ram_address, exp_ptr);
    check("coll_din", ram_din, 7'h5A);
    model_edit(7'h5A);
    cyc();
    #3;
    check("coll_eptr", edit_ptr, exp_ptr);
    cyc();

    // Reset while the 10th byte is being offered
    start_print();
    hs = 0;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      tx_ready = (hs < 9);
      #3;
      n++;
      if (tx_valid && tx_ready) hs++;
      else if (tx_valid && hs == 9) hit = 1'b1;
      if (!hit) cyc();
    end
    check("tenth_seen", hit, 1);
    check("tenth_byte", tx_data, exp_q[9]);
    reset = 1'b1;
    cyc();
    #3;
    check("midrst_txv", tx_valid, 0);
    check("midrst_busy", busy, 1);
    check("midrst_we", ram_write, 1);
    check("midrst_addr", ram_address, 24);
    reset_and_init();
    compare_mem();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
